// File: rtl/uart_rx_if.sv
// uart_rx consumer handshake: RDATA/RVALID toward the consumer,
// RREADY back; a pop happens on RVALID & RREADY.
interface uart_rx_if;
    logic [7:0] RDATA;
    logic       RVALID;
    logic       RREADY;

    modport master (
        output RDATA,
        output RVALID,
        input  RREADY
    );

    modport slave (
        input  RDATA,
        input  RVALID,
        output RREADY
    );
endinterface

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver with a small receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a live PERR output.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      RXD,
    uart_rx_if.master rx,
    output logic      FERR,
    output logic      PERR,
    output logic      OVERRUN
);

    localparam int DIV  = CLK_FREQ / (BAUD * 16);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] TOP  = CW'(DIV - 1);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t state;
    state_t nxt;

    logic [1:0]    sync;
    logic [1:0]    live;
    logic          prev;
    logic          rxs;
    logic          fall;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    tcnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          st_smp;
    logic          d_smp;
    logic          s_smp;
    logic          par_ok;
    logic          good;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [NW-1:0] count;
    logic          pop;
    logic          push_ok;

    assign rxs  = sync[1];
    assign fall = prev & ~rxs;
    assign tick = (cnt == TOP);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic p_smp;
    logic par_bit;

    assign par_ok = (par_bit == ^shreg);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            par_bit <= 1'b0;
            PERR    <= 1'b0;
        end else begin
            if (p_smp) par_bit <= rxs;
            PERR <= s_smp & rxs & ~par_ok;
        end
    end
`else
    assign par_ok = 1'b1;
    assign PERR   = 1'b0;
`endif

    always_comb begin
        nxt    = state;
        st_smp = 1'b0;
        d_smp  = 1'b0;
        s_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_smp  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (fall) nxt = START;
            end
            START: begin
                if (tick && tcnt == 4'd7) begin
                    st_smp = 1'b1;
                    nxt    = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tcnt == 4'd15) begin
                    d_smp = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bidx == 3'd7) nxt = PARITY;
`else
                    if (bidx == 3'd7) nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && tcnt == 4'd15) begin
                    p_smp = 1'b1;
                    nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && tcnt == 4'd15) begin
                    s_smp = 1'b1;
                    nxt   = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // prev stays 0 until the synchronizer holds real line data, so a
    // line already low at reset release is not taken as a start edge
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync  <= 2'b11;
            live  <= 2'b00;
            prev  <= 1'b0;
            cnt   <= '0;
            tcnt  <= 4'd0;
            bidx  <= 3'd0;
            shreg <= 8'h00;
        end else begin
            sync <= {sync[0], RXD};
            live <= {live[0], 1'b1};
            prev <= live[1] ? rxs : 1'b0;
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + 1'b1;
            if (state == IDLE)  tcnt <= 4'd0;
            else if (tick)      tcnt <= st_smp ? 4'd0 : tcnt + 4'd1;
            if (st_smp)         bidx <= 3'd0;
            else if (d_smp)     bidx <= bidx + 3'd1;
            if (d_smp) shreg <= {rxs, shreg[7:1]};
        end
    end

    assign good    = s_smp & rxs & par_ok;
    assign pop     = rx.RVALID & rx.RREADY;
    assign push_ok = good & ((count != FULL) | pop);

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wp] <= shreg;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            count   <= count + NW'(push_ok) - NW'(pop);
            FERR    <= s_smp & ~rxs;
            OVERRUN <= good & (count == FULL) & ~pop;
        end
    end

    assign rx.RVALID = (count != '0);
    assign rx.RDATA  = rx.RVALID ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx against a queue-based
// model of framing, FIFO occupancy and error pulses.
module tb_uart_rx;

    localparam int CLK_FREQ = 14745600;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * 16);
    localparam int BIT      = 16 * DIV;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic RXD = 1'b1;
    logic FERR;
    logic PERR;
    logic OVERRUN;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RXD    (RXD),
        .rx     (bus),
        .FERR   (FERR),
        .PERR   (PERR),
        .OVERRUN(OVERRUN)
    );

    always #10 CLK = ~CLK;

    logic [7:0] got [$];
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_ovr   = 0;
    int n_valid = 0;

    always @(negedge CLK) begin
        if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1)
            got.push_back(bus.RDATA);
        if (FERR === 1'b1)       n_ferr++;
        if (PERR === 1'b1)       n_perr++;
        if (OVERRUN === 1'b1)    n_ovr++;
        if (bus.RVALID === 1'b1) n_valid++;
    end

    int total = 0;
    int bad   = 0;
    int gi    = 0;
    int exp_ferr = 0;
    int exp_perr = 0;
    int exp_ovr  = 0;
    logic [7:0] mdl [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Line-level frame plus the model's view of what it should cause.
    task automatic send(input logic [7:0] b, input logic pflip,
                        input logic stopv);
        RXD = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            cyc(BIT);
        end
`ifdef UART_RX_PARITY_EN
        RXD = (^b) ^ pflip;
        cyc(BIT);
`endif
        RXD = stopv;
        cyc(BIT);
        RXD = 1'b1;
        if (!stopv) begin
            exp_ferr++;
            cyc(BIT);
        end else if (pflip) begin
`ifdef UART_RX_PARITY_EN
            exp_perr++;
`else
            mdl.push_back(b);
`endif
        end else if (bus.RREADY !== 1'b1 && mdl.size() >= DEPTH) begin
            exp_ovr++;
        end else begin
            mdl.push_back(b);
        end
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_cnt"}, got.size() - gi, mdl.size());
        while (mdl.size() > 0) begin
            logic [7:0] e;
            e = mdl.pop_front();
            chk(tag, (gi < got.size()) ? {24'h0, got[gi]} : 'x, e);
            gi++;
        end
        gi = got.size();
        chk({tag, "_ferr"}, n_ferr, exp_ferr);
        chk({tag, "_perr"}, n_perr, exp_perr);
        chk({tag, "_ovr"},  n_ovr,  exp_ovr);
    endtask

    initial begin
        bus.RREADY = 1'b0;
        cyc(4);
        chk("rst_rvalid",  bus.RVALID, 1'b0);
        chk("rst_rdata",   bus.RDATA,  8'h00);
        chk("rst_ferr",    FERR,       1'b0);
        chk("rst_perr",    PERR,       1'b0);
        chk("rst_overrun", OVERRUN,    1'b0);
        RST = 1'b1;
        cyc(1000);
        chk("idle_novalid", n_valid, 0);

        bus.RREADY = 1'b1;
        send(8'h55, 1'b0, 1'b1);
        send(8'hA3, 1'b0, 1'b1);
        cyc(BIT);
        check_rx("pair");

        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            logic       sv;
            logic       pf;
            b  = 8'($urandom);
            sv = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 3) == 0);
`else
            pf = 1'b0;
`endif
            send(b, pf, sv);
        end
        cyc(BIT);
        check_rx("rand");

        bus.RREADY = 1'b0;
        for (int k = 0; k < 16; k++) send(8'(k), 1'b0, 1'b1);
        cyc(BIT);
        chk("ovr_before", n_ovr, exp_ovr);
        send(8'h10, 1'b0, 1'b1);
        cyc(BIT);
        chk("ovr_after", n_ovr, exp_ovr);
        chk("full_valid", bus.RVALID, 1'b1);
        chk("full_head",  bus.RDATA,  8'h00);
        bus.RREADY = 1'b1;
        cyc(2 * DEPTH + 8);
        check_rx("drain");
        chk("drain_empty", bus.RVALID, 1'b0);

        RXD = 1'b0;
        cyc(4 * DIV);
        RXD = 1'b1;
        cyc(2 * BIT);
        check_rx("glitch");

        send(8'h7E, 1'b0, 1'b0);
        cyc(BIT);
        check_rx("badstop");

        RXD = 1'b0;
        cyc(30 * BIT);
        RXD = 1'b1;
        exp_ferr++;
        cyc(BIT);
        send(8'h31, 1'b0, 1'b1);
        cyc(BIT);
        check_rx("break");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        cyc(BIT);
        check_rx("par_bad");
        send(8'h07, 1'b0, 1'b1);
        cyc(BIT);
        check_rx("par_good");
`endif

        RXD = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            RXD = (8'hC4 >> i) & 8'h01;
            cyc(BIT);
        end
        RXD = 1'b0;
        cyc(BIT / 2);
        RST = 1'b0;
        cyc(4);
        chk("midrst_valid", bus.RVALID, 1'b0);
        RST = 1'b1;
        cyc(BIT / 2 - 4);
        for (int i = 4; i < 8; i++) begin
            RXD = (8'hC4 >> i) & 8'h01;
            cyc(BIT);
        end
        RXD = 1'b1;
        cyc(2 * BIT);
        check_rx("midrst");
        send(8'h5A, 1'b0, 1'b1);
        cyc(BIT);
        check_rx("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
